rng_share_ctrl: RTL and testbench
=================================

# rng_share_ctrl

Controller for the random generator: owns one 8-bit Galois LFSR and shares it among NUM_REQ requesters with round-robin arbitration. It handles reset and runtime seeding and a configurable warm-up. It hands out exactly one fresh random byte per grant. It sits between the 8-bit random state registers and the game-logic blocks that consume random values.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- SEED, 8'hA5: reset seed, also substituted for a zero seed; must be non-zero.
- WARMUP, 4: LFSR steps discarded after reset or seed load, 0..15.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- clr_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: global enable; low freezes all state and suppresses grants.
- seed_load, input, 1: load seed on the next edge; overrides en.
- seed, input, 8: seed value, sampled when seed_load = 1.
- req, input, NUM_REQ: level request per requester.
- gnt, output, NUM_REQ: registered one-hot grant, 1 cycle wide.
- rand_valid, output, 1: registered; equals |gnt.
- rand_out, output, 8: byte for the granted requester; holds its last value otherwise.
- ready, output, 1: high in READY state.

## Operation

- LFSR step: next = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00). Maximal period of 255. State is never 0.
- FSM states are WARM and READY.
  - WARM, cnt > 0, en = 1: step the LFSR and decrement cnt. When cnt goes 1→0, state becomes READY.
  - WARM, cnt = 0: state becomes READY on the next enabled edge with no step.
  - READY: on each enabled edge with |req, arbitrate.
- Arbitration in READY:
  - Winner w is the first set req bit at or after ptr, wrapping modulo NUM_REQ.
  - On that edge: gnt ← onehot(w), rand_out ← current LFSR value, LFSR steps, ptr ← (w+1) mod NUM_REQ.
- No request in READY: LFSR holds, gnt = 0.
- A requester holding req high is re-granted only in its round-robin turn. Each grant consumes exactly one distinct LFSR value.
- seed_load, in any state and regardless of en:
  - LFSR ← (seed == 0) ? SEED : seed.
  - cnt ← WARMUP, state ← WARM, gnt ← 0, rand_valid ← 0. ptr is unchanged.
- en = 0 without seed_load: LFSR, cnt, state and ptr hold; gnt ← 0, rand_valid ← 0; rand_out holds.
- Reset values: LFSR = SEED, cnt = WARMUP, state = WARM, ptr = 0, gnt = 0, rand_valid = 0, rand_out = 0, ready = 0.

## Timing

- Request in cycle t, with state READY and en = 1: gnt and rand_out are valid in cycle t+1, for 1 cycle.
- Throughput is one grant per cycle.
- seed_load sampled at edge k:
  - With WARMUP = W > 0: steps at edges k+1..k+W; READY after edge k+W; first grant at edge k+W+1 at the earliest.
  - With WARMUP = 0: READY after edge k+1.
- seed_load and req in the same cycle: load wins and no grant is issued that cycle.
- seed_load during an outstanding gnt: gnt drops on the load edge.
- en deasserted mid-warm-up: the remaining cnt is preserved and resumes when en returns.
- clr_n assertion clears all outputs immediately, asynchronously. Deassertion is synchronised externally.

## Structure

- Package rng_pkg holds:
  - the state enum (WARM, READY),
  - the LFSR tap constant 8'hB8,
  - the LFSR width constant 8,
  - a function lfsr_next(8-bit) returning 8-bit.
- Sub-module rr_arbiter, parameterised on NUM_REQ:
  - inputs: req, ptr;
  - outputs: one-hot winner and winner index;
  - purely combinational.
- The top level holds the FSM, cnt, ptr, the LFSR register and the output registers.

## Test plan

- Reset, hold req = 0: after WARMUP = 4 enabled cycles, ready = 1; gnt = 0, rand_out = 0 throughout.
- seed_load with seed = 8'h01, then req[0] held: ready rises 4 edges after load. rand_out sequence on successive grants is 8'h17, 8'hB3, 8'hE1, each with gnt = 4'b0001 and rand_valid = 1.
- In READY, req = 4'b1111 held for 4 cycles: gnt sequence is 0001, 0010, 0100, 1000, and all four rand_out values are distinct.
- seed_load with seed = 8'h00: LFSR loads 8'hA5; after warm-up the first grant returns the 4th step of 8'hA5, never 8'h00.
- en dropped for 3 cycles mid-warm-up with req high: no grants and the LFSR is frozen. After en returns, ready rises after the remaining steps only.
- seed_load asserted in the same cycle as req in READY: no gnt on that edge; state returns to WARM and ready = 0.

Source files
------------

// File: rtl/rng_share_ctrl_pkg.sv
// Shared definitions for the random generator controller: FSM state codes,
// LFSR geometry and the Galois step function.
package rng_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef logic [0:0] state_t;
    localparam state_t WARM  = 1'b0;
    localparam state_t READY = 1'b1;

    // Right-shifting Galois form; a non-zero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/rng_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx
);

    logic          found;
    logic [IW-1:0] cand;
    int unsigned   j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j    = (32'(ptr) + 32'(i)) % NUM_REQ;
            cand = IW'(j);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        onehot = found ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/rng_share_ctrl.sv
// Shares one 8-bit Galois LFSR among NUM_REQ requesters, one fresh byte per
// grant, with reset/runtime seeding and a discarded warm-up run.
module rng_share_ctrl
    import rng_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter logic [7:0]  SEED    = 8'hA5,
    parameter int unsigned WARMUP  = 4
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               en,
    input  logic               seed_load,
    input  logic [7:0]         seed,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rand_valid,
    output logic [7:0]         rand_out,
    output logic               ready
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [7:0]         lfsr_q, lfsr_d;
    logic [3:0]         cnt_q, cnt_d;
    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic [7:0]         rand_q, rand_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IW-1:0]      win_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (win_onehot),
        .idx    (win_idx)
    );

    always_comb begin
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        rand_d  = rand_q;
        if (seed_load) begin
            // A zero seed would lock the LFSR at zero.
            lfsr_d  = (seed == 8'h00) ? SEED : seed;
            cnt_d   = 4'(WARMUP);
            state_d = WARM;
        end else if (en) begin
            if (state_q == WARM) begin
                if (cnt_q != 4'd0) begin
                    lfsr_d = lfsr_next(lfsr_q);
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = READY;
                    end
                end else begin
                    state_d = READY;
                end
            end else if (|win_onehot) begin
                gnt_d   = win_onehot;
                valid_d = 1'b1;
                rand_d  = lfsr_q;
                lfsr_d  = lfsr_next(lfsr_q);
                ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lfsr_q  <= SEED;
            cnt_q   <= 4'(WARMUP);
            state_q <= WARM;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            rand_q  <= 8'h00;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            rand_q  <= rand_d;
        end
    end

    assign gnt        = gnt_q;
    assign rand_valid = valid_q;
    assign rand_out   = rand_q;
    assign ready      = (state_q == READY);

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench for rng_share_ctrl: a per-cycle reference model plus literal
// checks of the documented sequences.
module tb_rng_share_ctrl;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         en = 1'b0;
    logic         seed_load = 1'b0;
    logic [7:0]   seed = 8'h00;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         rand_valid;
    logic [7:0]   rand_out;
    logic         ready;

    int tests = 0;
    int fails = 0;

    rng_share_ctrl #(
        .NUM_REQ (N),
        .SEED    (8'hA5),
        .WARMUP  (W)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .en         (en),
        .seed_load  (seed_load),
        .seed       (seed),
        .req        (req),
        .gnt        (gnt),
        .rand_valid (rand_valid),
        .rand_out   (rand_out),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    // Reference model: warm-up is a count of steps still to discard.
    logic [7:0]   m_lfsr = 8'hA5;
    int           m_steps = W;
    bit           m_ready = 1'b0;
    int           m_ptr = 0;
    logic [N-1:0] e_gnt = '0;
    logic         e_valid = 1'b0;
    logic [7:0]   e_rand = 8'h00;

    always begin
        @(posedge clk);
        e_gnt   = '0;
        e_valid = 1'b0;
        if (!clr_n) begin
            m_lfsr = 8'hA5; m_steps = W; m_ready = 1'b0; m_ptr = 0; e_rand = 8'h00;
        end else if (seed_load) begin
            m_lfsr  = (seed == 8'h00) ? 8'hA5 : seed;
            m_steps = W;
            m_ready = 1'b0;
        end else if (en) begin
            if (!m_ready) begin
                if (m_steps > 0) begin
                    m_lfsr = step(m_lfsr);
                    m_steps--;
                end
                if (m_steps == 0) m_ready = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (e_valid == 1'b0 && req[c]) begin
                        e_gnt      = '0;
                        e_gnt[c]   = 1'b1;
                        e_valid    = 1'b1;
                        e_rand     = m_lfsr;
                        m_lfsr     = step(m_lfsr);
                        m_ptr      = (c + 1) % N;
                    end
                end
            end
        end
        #1;
        chk("model_gnt", 32'(gnt), 32'(e_gnt));
        chk("model_valid", 32'(rand_valid), 32'(e_valid));
        chk("model_rand", 32'(rand_out), 32'(e_rand));
        chk("model_ready", 32'(ready), 32'(m_ready));
    end

    logic [7:0] r [4];
    bit         distinct;

    initial begin
        // Reset, then warm-up with no requests.
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rand", 32'(rand_out), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        clr_n = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        chk("warm3_ready", 32'(ready), 32'h0);
        @(negedge clk);
        chk("warm4_ready", 32'(ready), 32'h1);
        chk("warm4_rand", 32'(rand_out), 32'h0);

        // Seed 0x01 then single requester.
        seed_load = 1'b1; seed = 8'h01;
        @(negedge clk);
        seed_load = 1'b0; req = 4'b0001;
        chk("load_ready", 32'(ready), 32'h0);
        repeat (3) @(negedge clk);
        chk("s1_ready_k3", 32'(ready), 32'h0);
        @(negedge clk);
        chk("s1_ready_k4", 32'(ready), 32'h1);
        chk("s1_gnt_k4", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("s1_gnt1", 32'(gnt), 32'b0001);
        chk("s1_rand1", 32'(rand_out), 32'h17);
        @(negedge clk);
        chk("s1_rand2", 32'(rand_out), 32'hB3);
        chk("s1_valid2", 32'(rand_valid), 32'h1);
        @(negedge clk);
        chk("s1_rand3", 32'(rand_out), 32'hE1);
        chk("s1_gnt3", 32'(gnt), 32'b0001);

        // Grant requester 3 so the pointer wraps to 0, then all four request.
        req = 4'b1000;
        @(negedge clk);
        chk("wrap_gnt", 32'(gnt), 32'b1000);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(gnt), 32'(1 << i));
            r[i] = rand_out;
        end
        req = '0;
        distinct = 1'b1;
        for (int a = 0; a < 4; a++)
            for (int b = a + 1; b < 4; b++)
                if (r[a] == r[b]) distinct = 1'b0;
        chk("rr_distinct", 32'(distinct), 32'h1);

        // Zero seed falls back to 0xA5; 4th step of 0xA5 is 0x41.
        @(negedge clk);
        seed_load = 1'b1; seed = 8'h00;
        @(negedge clk);
        seed_load = 1'b0; req = 4'b0001;
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk("z_rand", 32'(rand_out), 32'h41);
        chk("z_valid", 32'(rand_valid), 32'h1);
        req = '0;

        // en dropped for 3 cycles after two warm-up steps.
        @(negedge clk);
        seed_load = 1'b1; seed = 8'h01; req = 4'b1111;
        @(negedge clk);
        seed_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_ready", 32'(ready), 32'h0);
        chk("en_valid", 32'(rand_valid), 32'h0);
        en = 1'b1;
        @(negedge clk);
        chk("en_ready_k6", 32'(ready), 32'h0);
        @(negedge clk);
        chk("en_ready_k7", 32'(ready), 32'h1);
        @(negedge clk);
        chk("en_rand", 32'(rand_out), 32'h17);
        chk("en_valid_k8", 32'(rand_valid), 32'h1);

        // Load and request on the same edge while a grant is outstanding.
        seed_load = 1'b1; req = 4'b0001;
        @(negedge clk);
        chk("ld_req_gnt", 32'(gnt), 32'h0);
        chk("ld_req_ready", 32'(ready), 32'h0);
        seed_load = 1'b0; req = '0;
        repeat (6) @(negedge clk);
        req = 4'b0110;
        repeat (3) @(negedge clk);

        // Asynchronous reset clears outputs before any clock edge.
        #2 clr_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_rand", 32'(rand_out), 32'h0);
        chk("arst_ready", 32'(ready), 32'h0);
        chk("arst_valid", 32'(rand_valid), 32'h0);
        @(negedge clk);
        clr_n = 1'b1; req = '0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
